// File: rtl/msrv32_wb_arbiter_if.sv
// Write-back arbiter bus: producer handshakes (ALU, load issue, load response),
// flush, registered write port to the integer file and the pending-load mask.
interface msrv32_wb_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                     flush_in;
  logic                     alu_valid_in;
  logic [ADDR_WIDTH-1:0]    alu_rd_addr_in;
  logic [WIDTH-1:0]         alu_result_in;
  logic                     alu_ready_out;
  logic                     ld_issue_in;
  logic [ADDR_WIDTH-1:0]    ld_rd_addr_in;
  logic                     ld_issue_ready_out;
  logic                     ld_resp_valid_in;
  logic [WIDTH-1:0]         ld_resp_data_in;
  logic                     ld_resp_ready_out;
  logic                     wr_en_out;
  logic [ADDR_WIDTH-1:0]    rd_addr_out;
  logic [WIDTH-1:0]         rd_out;
  logic [2**ADDR_WIDTH-1:0] pending_mask_out;

  modport slave (
    input  flush_in, alu_valid_in, alu_rd_addr_in, alu_result_in,
           ld_issue_in, ld_rd_addr_in, ld_resp_valid_in, ld_resp_data_in,
    output alu_ready_out, ld_issue_ready_out, ld_resp_ready_out,
           wr_en_out, rd_addr_out, rd_out, pending_mask_out
  );

  modport master (
    output flush_in, alu_valid_in, alu_rd_addr_in, alu_result_in,
           ld_issue_in, ld_rd_addr_in, ld_resp_valid_in, ld_resp_data_in,
    input  alu_ready_out, ld_issue_ready_out, ld_resp_ready_out,
           wr_en_out, rd_addr_out, rd_out, pending_mask_out
  );
endinterface

// File: rtl/msrv32_wb_arbiter.sv
// Write-back arbiter: merges ALU results and in-order load responses into one
// registered integer-file write port. Outstanding load destinations live in a
// small FIFO; a per-register pending mask stalls WAW hazards on pending rds.
module msrv32_wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LD_DEPTH   = 4,
  parameter int PTR_WIDTH  = 2
) (
  input logic             msrv32_mp_clk_in,
  input logic             msrv32_mp_rst_in,
  msrv32_wb_arbiter_if.slave bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] fifo_mem [LD_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_p0, rd_ptr_p0;
  logic [PTR_WIDTH:0]    count_p0;
  logic [DEPTH-1:0]      mask_p0, mask_nxt;

  logic                  resp_rdy, resp_acc, issue_rdy, issue_acc, alu_rdy, alu_acc;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic                  wr_vld;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [WIDTH-1:0]      data_p1;

  // Handshake decisions; load responses take the write port ahead of the ALU.
  always_comb begin
    head_rd   = fifo_mem[rd_ptr_p0];
    resp_rdy  = (count_p0 != '0) & ~bus.flush_in;
    resp_acc  = bus.ld_resp_valid_in & resp_rdy;
    issue_rdy = ~bus.flush_in
              & ((count_p0 < (PTR_WIDTH+1)'(LD_DEPTH)) | resp_acc)
              & ((bus.ld_rd_addr_in == '0) | ~mask_p0[bus.ld_rd_addr_in]);
    issue_acc = bus.ld_issue_in & issue_rdy;
    alu_rdy   = ~bus.flush_in & ~resp_acc
              & ((bus.alu_rd_addr_in == '0) | ~mask_p0[bus.alu_rd_addr_in]);
    alu_acc   = bus.alu_valid_in & alu_rdy;
    wr_vld    = resp_acc | alu_acc;
    wr_addr   = resp_acc ? head_rd : bus.alu_rd_addr_in;
    wr_data   = resp_acc ? bus.ld_resp_data_in : bus.alu_result_in;
  end

  // Pending mask update: clear on response, set on issue, x0 never pending.
  always_comb begin
    mask_nxt = mask_p0;
    if (resp_acc) mask_nxt[head_rd] = 1'b0;
    if (issue_acc) mask_nxt[bus.ld_rd_addr_in] = 1'b1;
    mask_nxt[0] = 1'b0;
    if (bus.flush_in) mask_nxt = '0;
  end

  // FIFO control: pointers and occupancy; flush empties the queue.
  always_ff @(posedge msrv32_mp_clk_in) begin
    if (msrv32_mp_rst_in) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
      mask_p0   <= '0;
    end else if (bus.flush_in) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
      mask_p0   <= '0;
    end else begin
      if (issue_acc) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (resp_acc)  rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      count_p0 <= count_p0 + (PTR_WIDTH+1)'(issue_acc) - (PTR_WIDTH+1)'(resp_acc);
      mask_p0  <= mask_nxt;
    end
  end

  // FIFO storage of load destination registers.
  always_ff @(posedge msrv32_mp_clk_in) begin
    if (issue_acc) fifo_mem[wr_ptr_p0] <= bus.ld_rd_addr_in;
  end

  // ---- p0 -> p1: registered write port; x0 writes complete but never enable ----
  always_ff @(posedge msrv32_mp_clk_in) begin
    if (msrv32_mp_rst_in) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= wr_vld & (wr_addr != '0);
      if (wr_vld) begin
        addr_p1 <= wr_addr;
        data_p1 <= wr_data;
      end
    end
  end

  assign bus.ld_resp_ready_out  = resp_rdy;
  assign bus.ld_issue_ready_out = issue_rdy;
  assign bus.alu_ready_out      = alu_rdy;
  assign bus.wr_en_out          = vld_p1;
  assign bus.rd_addr_out        = addr_p1;
  assign bus.rd_out             = data_p1;
  assign bus.pending_mask_out   = mask_p0;

endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// Bench for msrv32_wb_arbiter: table of per-cycle vectors with hand-derived
// handshake and next-cycle output expectations, queued and compared after the edge.
module tb_msrv32_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msrv32_wb_arbiter_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

  msrv32_wb_arbiter #(.WIDTH(32), .ADDR_WIDTH(5), .LD_DEPTH(4), .PTR_WIDTH(2)) dut (
    .msrv32_mp_clk_in (clk),
    .msrv32_mp_rst_in (rst),
    .bus              (bus)
  );

  typedef struct {
    logic        rst, flush, alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        iss;
    logic [4:0]  ld_rd;
    logic        resp_v;
    logic [31:0] resp_d;
    logic        chk, e_alu, e_iss, e_resp;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_mask;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data, mask;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   step   = 0;
  vec_t tbl[$];

  function automatic vec_t V(
    input logic r, input logic f, input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic is, input logic [4:0] lrd, input logic rv, input logic [31:0] rd,
    input logic c, input logic ea, input logic ei, input logic er,
    input logic ew, input logic [4:0] eaddr, input logic [31:0] edata, input logic [31:0] emask);
    vec_t v;
    v.rst = r; v.flush = f; v.alu_v = av; v.alu_rd = ard; v.alu_d = ad;
    v.iss = is; v.ld_rd = lrd; v.resp_v = rv; v.resp_d = rd;
    v.chk = c; v.e_alu = ea; v.e_iss = ei; v.e_resp = er;
    v.e_wr = ew; v.e_addr = eaddr; v.e_data = edata; v.e_mask = emask;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    string tag;
    tag = $sformatf("s%0d", step);
    @(negedge clk);
    rst                  = v.rst;
    bus.flush_in         = v.flush;
    bus.alu_valid_in     = v.alu_v;
    bus.alu_rd_addr_in   = v.alu_rd;
    bus.alu_result_in    = v.alu_d;
    bus.ld_issue_in      = v.iss;
    bus.ld_rd_addr_in    = v.ld_rd;
    bus.ld_resp_valid_in = v.resp_v;
    bus.ld_resp_data_in  = v.resp_d;
    #1;
    if (v.chk) begin
      check({tag, " alu_ready"},   32'(bus.alu_ready_out),      32'(v.e_alu));
      check({tag, " issue_ready"}, 32'(bus.ld_issue_ready_out), 32'(v.e_iss));
      check({tag, " resp_ready"},  32'(bus.ld_resp_ready_out),  32'(v.e_resp));
    end
    e.wr = v.e_wr; e.addr = v.e_addr; e.data = v.e_data; e.mask = v.e_mask;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " wr_en"},   32'(bus.wr_en_out),   32'(e.wr));
      check({tag, " rd_addr"}, 32'(bus.rd_addr_out), 32'(e.addr));
      check({tag, " rd"},      bus.rd_out,           e.data);
      check({tag, " mask"},    bus.pending_mask_out, e.mask);
    end
    step++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.flush_in = 0; bus.alu_valid_in = 0; bus.alu_rd_addr_in = 0; bus.alu_result_in = 0;
    bus.ld_issue_in = 0; bus.ld_rd_addr_in = 0; bus.ld_resp_valid_in = 0; bus.ld_resp_data_in = 0;

    //          rst f av ard ad            is lrd rv rd        c ea ei er  ew addr data          mask
    tbl.push_back(V(1,0,0,0, 0,            0,0, 0,0,          0,0,0,0,  0,0, 0,            32'h0));
    tbl.push_back(V(0,0,1,5, 32'hDEADBEEF, 0,0, 0,0,          1,1,1,0,  1,5, 32'hDEADBEEF, 32'h0));
    tbl.push_back(V(0,0,0,0, 0,            1,1, 0,0,          1,1,1,0,  0,5, 32'hDEADBEEF, 32'h2));
    tbl.push_back(V(0,0,0,0, 0,            1,2, 0,0,          1,1,1,1,  0,5, 32'hDEADBEEF, 32'h6));
    tbl.push_back(V(1,0,1,7, 32'h1234,     0,0, 1,32'h55,     0,0,0,0,  0,0, 0,            32'h0));
    tbl.push_back(V(0,0,0,0, 0,            0,0, 0,0,          1,1,1,0,  0,0, 0,            32'h0));
    tbl.push_back(V(0,0,0,0, 0,            1,1, 0,0,          1,1,1,0,  0,0, 0,            32'h2));
    tbl.push_back(V(0,0,0,0, 0,            1,2, 0,0,          1,1,1,1,  0,0, 0,            32'h6));
    tbl.push_back(V(0,0,0,0, 0,            1,3, 0,0,          1,1,1,1,  0,0, 0,            32'hE));
    tbl.push_back(V(0,0,0,0, 0,            1,4, 0,0,          1,1,1,1,  0,0, 0,            32'h1E));
    tbl.push_back(V(0,0,0,0, 0,            1,6, 0,0,          1,1,0,1,  0,0, 0,            32'h1E));
    tbl.push_back(V(0,0,0,0, 0,            0,0, 1,32'h11,     1,0,1,1,  1,1, 32'h11,       32'h1C));
    tbl.push_back(V(0,0,1,3, 32'hAAAA0003, 0,0, 0,0,          1,0,1,1,  0,1, 32'h11,       32'h1C));
    tbl.push_back(V(0,0,1,3, 32'hAAAA0003, 0,0, 1,32'h22,     1,0,1,1,  1,2, 32'h22,       32'h18));
    tbl.push_back(V(0,0,1,3, 32'hAAAA0003, 0,0, 1,32'h33,     1,0,1,1,  1,3, 32'h33,       32'h10));
    tbl.push_back(V(0,0,1,3, 32'hAAAA0003, 0,0, 0,0,          1,1,1,1,  1,3, 32'hAAAA0003, 32'h10));
    tbl.push_back(V(0,0,1,0, 32'h99,       1,0, 0,0,          1,1,1,1,  0,0, 32'h99,       32'h10));
    tbl.push_back(V(0,0,0,0, 0,            0,0, 1,32'h44,     1,0,1,1,  1,4, 32'h44,       32'h0));
    tbl.push_back(V(0,0,0,0, 0,            0,0, 0,0,          1,1,1,1,  0,4, 32'h44,       32'h0));
    tbl.push_back(V(0,0,0,0, 0,            0,0, 1,32'h77,     1,0,1,1,  0,0, 32'h77,       32'h0));
    tbl.push_back(V(0,0,0,0, 0,            0,0, 0,0,          1,1,1,0,  0,0, 32'h77,       32'h0));
    tbl.push_back(V(0,0,0,0, 0,            1,7, 0,0,          1,1,1,0,  0,0, 32'h77,       32'h80));
    tbl.push_back(V(0,0,0,0, 0,            1,8, 0,0,          1,1,1,1,  0,0, 32'h77,       32'h180));
    tbl.push_back(V(0,0,0,0, 0,            1,9, 0,0,          1,1,1,1,  0,0, 32'h77,       32'h380));
    tbl.push_back(V(0,1,1,11,32'h5A,       1,10,1,32'h5,      1,0,0,0,  0,0, 32'h77,       32'h0));
    tbl.push_back(V(0,0,0,0, 0,            0,0, 1,32'h6,      1,1,1,0,  0,0, 32'h77,       32'h0));
    tbl.push_back(V(0,0,1,1, 32'hBB,       1,1, 0,0,          1,1,1,0,  1,1, 32'hBB,       32'h2));

    foreach (tbl[i]) apply(tbl[i]);

    // ALU write to a pending register stays stalled across several cycles.
    for (int k = 0; k < 5; k++)
      apply(V(0,0,1,1,32'hE1, 0,0, 0,0, 1,0,1,1, 0,1,32'hBB, 32'h2));

    // Fill the FIFO, then push and pop in the same cycle while full (pointer wrap).
    apply(V(0,0,0,0,0, 1,2, 0,0,         1,1,1,1, 0,1,32'hBB, 32'h6));
    apply(V(0,0,0,0,0, 1,3, 0,0,         1,1,1,1, 0,1,32'hBB, 32'hE));
    apply(V(0,0,0,0,0, 1,4, 0,0,         1,1,1,1, 0,1,32'hBB, 32'h1E));
    apply(V(0,0,1,1,32'hE1, 1,5, 1,32'hC1, 1,0,1,1, 1,1,32'hC1, 32'h3C));
    apply(V(0,0,1,1,32'hE1, 0,0, 0,0,    1,1,0,1, 1,1,32'hE1, 32'h3C));
    apply(V(0,0,0,0,0, 0,0, 1,32'hC2,    1,0,1,1, 1,2,32'hC2, 32'h38));
    apply(V(0,0,0,0,0, 0,0, 1,32'hC3,    1,0,1,1, 1,3,32'hC3, 32'h30));
    apply(V(0,0,0,0,0, 0,0, 1,32'hC4,    1,0,1,1, 1,4,32'hC4, 32'h20));
    apply(V(0,0,0,0,0, 0,0, 1,32'hC5,    1,0,1,1, 1,5,32'hC5, 32'h0));
    apply(V(0,0,0,0,0, 0,0, 1,32'hC6,    1,1,1,0, 0,5,32'hC5, 32'h0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
